pcm_expand: RTL and testbench

G.711 PCM-to-linear expander for the G.726 ADPCM codec datapath. It converts an 8-bit A-law or µ-law codeword into the 14-bit two's-complement uniform sample SL, per the G.726 EXPAND function. It is shared by the encoder (input PCM S to SL) and the decoder (SP to SLX for synchronous coding adjustment). The output is registered with a valid strobe.

---
 rtl/pcm_expand_if.sv | 36 +++
 rtl/pcm_expand.sv | 126 ++++++++++++
 tb/tb_pcm_expand.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_expand_if.sv
// ============================================================================
// Module      : pcm_expand_if
// Description : Sample bus for the G.711 PCM-to-linear expander.
//               It carries the PCM codeword, the law select and the input
//               strobe, plus the registered linear sample and its strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pcm_expand_if;
    logic [7:0]  SIN;
    logic        LAW;
    logic        in_valid;
    logic [13:0] SOUT;
    logic        out_valid;

    // The source of codewords drives the inputs and observes the result.
    modport master (
        output SIN,
        output LAW,
        output in_valid,
        input  SOUT,
        input  out_valid
    );

    // The expander consumes codewords and produces linear samples.
    modport slave (
        input  SIN,
        input  LAW,
        input  in_valid,
        output SOUT,
        output out_valid
    );
endinterface

`default_nettype wire

// File: rtl/pcm_expand.sv
// ============================================================================
// Module      : pcm_expand
// Description : G.711 A-law / mu-law to 14-bit two's-complement linear
//               expander (G.726 EXPAND). Registered output with a valid
//               strobe, one sample per clock.
//               Optional macro EXPAND_PIPE_EN adds a register stage between
//               the sign/magnitude decode and the final negation. This gives
//               2-cycle latency and leaves the output values unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcm_expand (
    input  logic         clk,
    input  logic         reset,
    pcm_expand_if.slave  bus
);

    // Decode results: sign and unsigned magnitude, both below 8192.
    logic [7:0]  a_t;
    logic [6:0]  u_t;
    logic [2:0]  seg;
    logic [3:0]  mant;
    logic [13:0] base;
    logic        neg_w;
    logic [13:0] mag_w;

    // Sign and magnitude decode for both laws.
    always_comb begin
        a_t   = bus.SIN ^ 8'h55;
        u_t   = ~bus.SIN[6:0];
        seg   = 3'd0;
        mant  = 4'd0;
        base  = 14'd0;
        neg_w = 1'b0;
        mag_w = 14'd0;
        if (bus.LAW) begin
            // A-law: bit 7 set after de-inversion means positive.
            neg_w = ~a_t[7];
            seg   = a_t[6:4];
            mant  = a_t[3:0];
            base  = {9'd0, mant, 1'b1} + 14'd32;
            // Segment 0 has no implied leading one: 2*(2*mant+1).
            if (seg == 3'd0) begin
                mag_w = {8'd0, mant, 2'b10};
            end else begin
                mag_w = base << seg;
            end
        end else begin
            // mu-law: bias of 33 is added before shifting and removed after.
            neg_w = ~bus.SIN[7];
            seg   = u_t[6:4];
            mant  = u_t[3:0];
            base  = {9'd0, mant, 1'b1} + 14'd32;
            mag_w = (base << seg) - 14'd33;
        end
    end

    logic [13:0] sout_d, sout_q;
    logic        out_valid_d, out_valid_q;

`ifdef EXPAND_PIPE_EN
    logic        s1_valid_d, s1_valid_q;
    logic        s1_neg_d, s1_neg_q;
    logic [13:0] s1_mag_d, s1_mag_q;

    // Next-state for the decode stage and the negation/output stage.
    always_comb begin
        s1_valid_d  = bus.in_valid;
        s1_neg_d    = s1_neg_q;
        s1_mag_d    = s1_mag_q;
        sout_d      = sout_q;
        out_valid_d = s1_valid_q;
        if (bus.in_valid) begin
            s1_neg_d = neg_w;
            s1_mag_d = mag_w;
        end
        if (s1_valid_q) begin
            sout_d = s1_neg_q ? (14'd0 - s1_mag_q) : s1_mag_q;
        end
    end

    // Both stages and both valid bits clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_mag_q    <= 14'd0;
            sout_q      <= 14'd0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_neg_q    <= s1_neg_d;
            s1_mag_q    <= s1_mag_d;
            sout_q      <= sout_d;
            out_valid_q <= out_valid_d;
        end
    end
`else
    // Negate in the same cycle; hold the last sample while idle.
    always_comb begin
        sout_d      = sout_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            sout_d = neg_w ? (14'd0 - mag_w) : mag_w;
        end
    end

    // Single output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sout_q      <= 14'd0;
            out_valid_q <= 1'b0;
        end else begin
            sout_q      <= sout_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign bus.SOUT      = sout_q;
    assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pcm_expand.sv
// ============================================================================
// Module      : tb_pcm_expand
// Description : Self-checking bench for pcm_expand: law extremes, exhaustive
//               sweep with the law toggling each cycle, gaps and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcm_expand;

`ifdef EXPAND_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    pcm_expand_if bus ();

    pcm_expand dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected-output model: history of captured samples, newest at index 0.
    logic [2:0]  hv;
    logic [13:0] hd [0:2];
    logic [13:0] exp_sout;
    logic        exp_valid;

    // Reference expansion in the classic 16-bit G.711 form, scaled to 14 bits.
    function automatic logic [13:0] golden(input logic [7:0] s, input logic law);
        int a;
        int t;
        int sg;
        logic [31:0] r;
        if (law) begin
            a  = int'(s ^ 8'h55);
            t  = (a & 15) << 4;
            sg = (a >> 4) & 7;
            case (sg)
                0:       t = t + 8;
                1:       t = t + 264;
                default: t = (t + 264) << (sg - 1);
            endcase
            if ((a & 128) == 0) t = -t;
        end else begin
            a = int'(~s) & 255;
            t = (((a & 15) << 3) + 132) << ((a & 112) >> 4);
            if ((a & 128) != 0) t = 132 - t;
            else                t = t - 132;
        end
        t = t >>> 2;
        r = t;
        return r[13:0];
    endfunction

    // Apply one cycle of stimulus and advance the expected-output model.
    task automatic tick(input logic v, input logic [7:0] s, input logic l, input logic r);
        bus.in_valid = v;
        bus.SIN      = s;
        bus.LAW      = l;
        reset        = r;
        @(posedge clk);
        #1;
        if (r) begin
            hv        = 3'b000;
            exp_sout  = 14'd0;
            exp_valid = 1'b0;
        end else begin
            hv    = {hv[1:0], v};
            hd[2] = hd[1];
            hd[1] = hd[0];
            hd[0] = golden(s, l);
            exp_valid = hv[LAT-1];
            if (hv[LAT-1]) exp_sout = hd[LAT-1];
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 8'hAA, 1'b1, 1'b1);
        tick(1'b1, 8'h2A, 1'b1, 1'b1);
        n_checks++;
        if (bus.SOUT !== 14'h0000) begin
            n_fail++;
            $display("FAIL reset_sout: got %h want 0000", bus.SOUT);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_extremes();
        logic [7:0]  sins [8] = '{8'hD5, 8'h55, 8'hAA, 8'h2A, 8'hFF, 8'h7F, 8'h80, 8'h00};
        logic        laws [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [13:0] exps [8] = '{14'h0002, 14'h3FFE, 14'h1F80, 14'h2080,
                                  14'h0000, 14'h0000, 14'h1F5F, 14'h20A1};
        for (int i = 0; i < 8; i++) begin
            // Preload SOUT with a non-zero value so zero results are visible.
            tick(1'b1, 8'h80, 1'b0, 1'b0);
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            tick(1'b1, sins[i], laws[i], 1'b0);
            for (int k = 1; k < LAT; k++) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL extreme_early_valid[%0d]: got %b want 0", i, bus.out_valid);
                end
                tick(1'b0, 8'h00, 1'b0, 1'b0);
            end
            n_checks++;
            if (bus.SOUT !== exps[i] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL extreme[%0d] sin=%h law=%b: got %h/%b want %h/1",
                         i, sins[i], laws[i], bus.SOUT, bus.out_valid, exps[i]);
            end
            tick(1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] idx;
        for (int i = 0; i < 512 + LAT; i++) begin
            idx = 9'(i);
            if (i < 512) tick(1'b1, idx[8:1], idx[0], 1'b0);
            else         tick(1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (bus.SOUT !== exp_sout || bus.out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got %h/%b want %h/%b",
                         i, bus.SOUT, bus.out_valid, exp_sout, exp_valid);
            end
            if (i >= LAT - 1 && i < 512 + LAT - 1) begin
                n_checks++;
                if (bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.out_valid);
                end
            end
        end
    endtask

    task automatic test_gap();
        logic       vpat [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] spat [3] = '{8'hAA, 8'h55, 8'hD5};
        for (int i = 0; i < 3 + LAT; i++) begin
            if (i < 3) tick(vpat[i], spat[i], 1'b1, 1'b0);
            else       tick(1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (bus.SOUT !== exp_sout || bus.out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL gap[%0d]: got %h/%b want %h/%b",
                         i, bus.SOUT, bus.out_valid, exp_sout, exp_valid);
            end
            // During the gap cycle the first sample must be held.
            if (i == LAT) begin
                n_checks++;
                if (bus.SOUT !== 14'h1F80 || bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_hold: got %h/%b want 1f80/0", bus.SOUT, bus.out_valid);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        tick(1'b1, 8'hAA, 1'b1, 1'b0);
        tick(1'b1, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 8'h2A, 1'b1, 1'b1);
        n_checks++;
        if (bus.SOUT !== 14'h0000 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: got %h/%b want 0000/0", bus.SOUT, bus.out_valid);
        end
        for (int i = 0; i < 4 + LAT; i++) begin
            if (i < 4) tick(1'b1, 8'(8'h80 + 8'(i)), 1'(i & 1), 1'b0);
            else       tick(1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++;
            if (bus.SOUT !== exp_sout || bus.out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL resume[%0d]: got %h/%b want %h/%b",
                         i, bus.SOUT, bus.out_valid, exp_sout, exp_valid);
            end
        end
        // First output after reset: mu-law 0x80 appears exactly LAT cycles on.
        tick(1'b1, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h80, 1'b0, 1'b0);
        for (int k = 1; k < LAT; k++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (bus.SOUT !== 14'h1F5F || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_latency: got %h/%b want 1f5f/1", bus.SOUT, bus.out_valid);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        hv        = 3'b000;
        hd[0]     = 14'd0;
        hd[1]     = 14'd0;
        hd[2]     = 14'd0;
        exp_sout  = 14'd0;
        exp_valid = 1'b0;
        bus.SIN      = 8'h00;
        bus.LAW      = 1'b0;
        bus.in_valid = 1'b0;
        test_reset();
        test_extremes();
        test_back_to_back();
        test_gap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
